hyperram_bus_arbiter: RTL and testbench

- Owns the shared HyperRAM pin bus between two masters: the IR capture FPGA, which writes frames, and the local burst reader, which reads them back and uploads them.
- Filters the IR FPGA's asynchronous request/done strobes and sequences bus ownership with turnaround gaps.
- Enforces the HyperRAM maximum CE-low width on local read bursts.
- Drives the mux select that chooses the source of PSRAM CLK/CE/ADQ.

---
 rtl/hyperram_bus_arbiter_if.sv | 25 ++
 rtl/hyperram_bus_arbiter.sv | 156 +++++++++++++++
 tb/tb_hyperram_bus_arbiter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/hyperram_bus_arbiter_if.sv
// Signal bundle between the HyperRAM bus arbiter and its two requesters.
// The slave modport is the arbiter's view; the master modport is the requesters' view.
interface hyperram_bus_arbiter_if;
    logic       ir_wr_req_i;
    logic       ir_wr_done_i;
    logic       rd_req_i;
    logic       rd_done_i;
    logic       rd_gnt_o;
    logic       rd_abort_o;
    logic       preempt_o;
    logic       which_wr_o;
    logic       frame_ready_o;
    logic [2:0] state_o;
    logic [7:0] abort_cnt_o;

    modport master (
        output ir_wr_req_i, ir_wr_done_i, rd_req_i, rd_done_i,
        input  rd_gnt_o, rd_abort_o, preempt_o, which_wr_o, frame_ready_o, state_o, abort_cnt_o
    );

    modport slave (
        input  ir_wr_req_i, ir_wr_done_i, rd_req_i, rd_done_i,
        output rd_gnt_o, rd_abort_o, preempt_o, which_wr_o, frame_ready_o, state_o, abort_cnt_o
    );
endinterface

// File: rtl/hyperram_bus_arbiter.sv
// Shares the HyperRAM pin bus between the IR capture FPGA (writer) and the local burst reader,
// with filtered IR strobes, turnaround gaps and a hard cap on local CE-low time.
module hyperram_bus_arbiter #(
    parameter int FILTER_LEN    = 20,
    parameter int TURN_CYC      = 4,
    parameter int MAX_BURST_CYC = 96
) (
    input  logic                  clk_48MHz,
    input  logic                  rst_n,
    hyperram_bus_arbiter_if.slave bus
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int CW = $clog2(MAX_BURST_CYC + TURN_CYC + 1);

    typedef enum logic [2:0] {
        IR_OWN     = 3'd0,
        TURN_L     = 3'd1,
        LOCAL_OWN  = 3'd2,
        LOCAL_HOLD = 3'd3,
        TURN_I     = 3'd4
    } ArbState;

    ArbState         state;
    ArbState         stateNext;
    logic [1:0]      syncA;
    logic [1:0]      syncB;
    logic [1:0]      filt;
    logic [FW-1:0]   runCnt [2];
    logic [1:0]      filtRise;
    logic            reqF;
    logic            reqRise;
    logic            doneRise;
    logic            frameReady;
    logic [CW-1:0]   phaseCnt;
    logic [7:0]      abortCnt;
    logic            gnt;
    logic            whichWr;
    logic            abortPulse;
    logic            preempt;

    // Index 0 carries the IR write request, index 1 the IR write done strobe.
    always_ff @(posedge clk_48MHz or negedge rst_n) begin
        if (!rst_n) begin
            syncA     <= '0;
            syncB     <= '0;
            filt      <= '0;
            runCnt[0] <= '0;
            runCnt[1] <= '0;
        end else begin
            syncA <= {bus.ir_wr_done_i, bus.ir_wr_req_i};
            syncB <= syncA;
            for (int i = 0; i < 2; i++) begin
                if (syncB[i] == filt[i]) begin
                    runCnt[i] <= '0;
                end else if (runCnt[i] == FW'(FILTER_LEN - 1)) begin
                    filt[i]   <= syncB[i];
                    runCnt[i] <= '0;
                end else begin
                    runCnt[i] <= runCnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        filtRise = '0;
        for (int i = 0; i < 2; i++) begin
            filtRise[i] = syncB[i] & ~filt[i] & (runCnt[i] == FW'(FILTER_LEN - 1));
        end
    end

    assign reqF     = filt[0];
    assign reqRise  = filtRise[0];
    assign doneRise = filtRise[1];

    // A new write request invalidates the frame even if a done edge lands in the same cycle.
    always_ff @(posedge clk_48MHz or negedge rst_n) begin
        if (!rst_n) begin
            frameReady <= 1'b0;
        end else if (reqRise) begin
            frameReady <= 1'b0;
        end else if (doneRise) begin
            frameReady <= 1'b1;
        end
    end

    always_ff @(posedge clk_48MHz or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IR_OWN;
            phaseCnt <= '0;
            abortCnt <= '0;
        end else begin
            state <= stateNext;
            if (stateNext != state) begin
                phaseCnt <= '0;
            end else if (state == TURN_L || state == LOCAL_OWN || state == TURN_I) begin
                phaseCnt <= phaseCnt + 1'b1;
            end
            if (abortPulse && abortCnt != 8'hFF) begin
                abortCnt <= abortCnt + 1'b1;
            end
        end
    end

    // The local side owns the mux in every state except IR_OWN, so the grant never overlaps an IR-driven bus.
    always_comb begin
        stateNext  = state;
        gnt        = 1'b0;
        whichWr    = 1'b1;
        abortPulse = 1'b0;
        preempt    = 1'b0;
        case (state)
            IR_OWN: begin
                whichWr = 1'b0;
                if (frameReady && bus.rd_req_i && !reqF) stateNext = TURN_L;
            end
            TURN_L: begin
                if (phaseCnt == CW'(TURN_CYC - 1)) stateNext = LOCAL_OWN;
            end
            LOCAL_OWN: begin
                gnt     = 1'b1;
                preempt = reqF;
                if (bus.rd_done_i) begin
                    stateNext = LOCAL_HOLD;
                end else if (phaseCnt == CW'(MAX_BURST_CYC - 1)) begin
                    abortPulse = 1'b1;
                    stateNext  = LOCAL_HOLD;
                end
            end
            LOCAL_HOLD: begin
                if (reqF) begin
                    stateNext = TURN_I;
                end else if (bus.rd_req_i && frameReady) begin
                    stateNext = LOCAL_OWN;
                end
            end
            TURN_I: begin
                if (phaseCnt == CW'(TURN_CYC - 1)) stateNext = IR_OWN;
            end
            default: begin
                whichWr   = 1'b0;
                stateNext = IR_OWN;
            end
        endcase
    end

    assign bus.rd_gnt_o      = gnt;
    assign bus.rd_abort_o    = abortPulse;
    assign bus.preempt_o     = preempt;
    assign bus.which_wr_o    = whichWr;
    assign bus.frame_ready_o = frameReady;
    assign bus.state_o       = state;
    assign bus.abort_cnt_o   = abortCnt;

endmodule

// File: tb/tb_hyperram_bus_arbiter.sv
// Randomized and directed bench for hyperram_bus_arbiter, compared every cycle against
// a behavioural model built from sample histories and per-phase cycle counts.
module tb_hyperram_bus_arbiter;

    localparam int FILTER_LEN    = 20;
    localparam int TURN_CYC      = 4;
    localparam int MAX_BURST_CYC = 96;
    localparam int PH_IR    = 0;
    localparam int PH_TURNL = 1;
    localparam int PH_LOCAL = 2;
    localparam int PH_HOLD  = 3;
    localparam int PH_TURNI = 4;

    logic clk_48MHz = 1'b0;
    logic rst_n     = 1'b0;
    hyperram_bus_arbiter_if bus ();

    hyperram_bus_arbiter #(
        .FILTER_LEN(FILTER_LEN), .TURN_CYC(TURN_CYC), .MAX_BURST_CYC(MAX_BURST_CYC)
    ) dut (
        .clk_48MHz(clk_48MHz),
        .rst_n    (rst_n),
        .bus      (bus)
    );

    always #5 clk_48MHz = ~clk_48MHz;

    int checkCount = 0;
    int passCount  = 0;

    logic [FILTER_LEN:0] reqHist;
    logic [FILTER_LEN:0] doneHist;
    bit  mReqF, mDoneF, mFr;
    int  mPhase, mElapsed, mAborts, mAbortTotal;

    task automatic checkOutput(input string tag, input int got, input int exp);
        checkCount++;
        if (got == exp) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic applyStimulus(input bit wrReq, input bit wrDone, input bit rdReq, input bit rdDone);
        @(negedge clk_48MHz);
        bus.ir_wr_req_i  = wrReq;
        bus.ir_wr_done_i = wrDone;
        bus.rd_req_i     = rdReq;
        bus.rd_done_i    = rdDone;
    endtask

    function automatic void modelReset();
        reqHist  = '0;
        doneHist = '0;
        mReqF    = 0;
        mDoneF   = 0;
        mFr      = 0;
        mPhase   = PH_IR;
        mElapsed = 0;
        mAborts  = 0;
    endfunction

    // A filtered level flips once the synchronized input (two samples late) has held the other level FILTER_LEN cycles.
    function automatic void modelStep();
        bit reqRise, reqFall, doneRise, doneFall;
        reqRise  = !mReqF  && (reqHist[FILTER_LEN:1]  == {FILTER_LEN{1'b1}});
        reqFall  =  mReqF  && (reqHist[FILTER_LEN:1]  == {FILTER_LEN{1'b0}});
        doneRise = !mDoneF && (doneHist[FILTER_LEN:1] == {FILTER_LEN{1'b1}});
        doneFall =  mDoneF && (doneHist[FILTER_LEN:1] == {FILTER_LEN{1'b0}});
        case (mPhase)
            PH_IR: if (mFr && bus.rd_req_i && !mReqF) begin mPhase = PH_TURNL; mElapsed = 0; end
            PH_TURNL, PH_TURNI: begin
                mElapsed++;
                if (mElapsed == TURN_CYC) begin
                    mPhase   = (mPhase == PH_TURNL) ? PH_LOCAL : PH_IR;
                    mElapsed = 0;
                end
            end
            PH_LOCAL: begin
                if (bus.rd_done_i) begin
                    mPhase = PH_HOLD; mElapsed = 0;
                end else if (mElapsed == MAX_BURST_CYC - 1) begin
                    mPhase = PH_HOLD; mElapsed = 0;
                    mAbortTotal++;
                    if (mAborts < 255) mAborts++;
                end else begin
                    mElapsed++;
                end
            end
            default: begin
                if (mReqF) begin mPhase = PH_TURNI; mElapsed = 0; end
                else if (bus.rd_req_i && mFr) begin mPhase = PH_LOCAL; mElapsed = 0; end
            end
        endcase
        if (reqRise) mReqF = 1;
        if (reqFall) mReqF = 0;
        if (doneRise) mDoneF = 1;
        if (doneFall) mDoneF = 0;
        if (reqRise) mFr = 0;
        else if (doneRise) mFr = 1;
        reqHist  = {reqHist[FILTER_LEN-1:0], bus.ir_wr_req_i};
        doneHist = {doneHist[FILTER_LEN-1:0], bus.ir_wr_done_i};
    endfunction

    always @(negedge rst_n) modelReset();

    always @(posedge clk_48MHz) begin
        if (!rst_n) modelReset();
        else modelStep();
        #1;
        checkOutput("whichWr",    bus.which_wr_o,    (mPhase != PH_IR) ? 1 : 0);
        checkOutput("rdGnt",      bus.rd_gnt_o,      (mPhase == PH_LOCAL) ? 1 : 0);
        checkOutput("rdAbort",    bus.rd_abort_o,
                    (mPhase == PH_LOCAL && mElapsed == MAX_BURST_CYC - 1 && !bus.rd_done_i) ? 1 : 0);
        checkOutput("preempt",    bus.preempt_o,     (mPhase == PH_LOCAL && mReqF) ? 1 : 0);
        checkOutput("frameReady", bus.frame_ready_o, mFr ? 1 : 0);
        checkOutput("state",      bus.state_o,       mPhase);
        checkOutput("abortCnt",   bus.abort_cnt_o,   mAborts);
    end

    initial begin
        int  lat;
        bit  seen;
        int  savedCnt;
        int  reqHold, doneHold, rdHold;
        bit  rReq, rDone, rRd;
        mAbortTotal = 0;
        modelReset();
        bus.ir_wr_req_i  = 0;
        bus.ir_wr_done_i = 0;
        bus.rd_req_i     = 0;
        bus.rd_done_i    = 0;
        repeat (3) @(negedge clk_48MHz);
        checkOutput("resetState", bus.state_o, 0);
        checkOutput("resetWhich", bus.which_wr_o, 0);
        rst_n = 1'b1;

        // A 15-cycle done strobe is too short to pass the filter.
        for (int i = 0; i < 15; i++) applyStimulus(0, 1, 0, 0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(0, 0, 1, 0);
            seen |= bus.rd_gnt_o;
        end
        checkOutput("glitchNoGnt", seen, 0);
        checkOutput("glitchFr", bus.frame_ready_o, 0);

        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            applyStimulus(0, (i <= 30), 0, 0);
            if (bus.frame_ready_o && lat == 0) lat = i - 1;
        end
        checkOutput("frLatency", lat, 22);

        // Land rd_done_i exactly on the timeout cycle: done must win.
        seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk_48MHz);
            bus.rd_req_i  = 1;
            bus.rd_done_i = (mPhase == PH_LOCAL && mElapsed == MAX_BURST_CYC - 1);
            if (bus.rd_done_i) begin
                seen     = 1;
                savedCnt = mAborts;
                @(negedge clk_48MHz);
                bus.rd_done_i = 0;
                checkOutput("coincAbortCnt", bus.abort_cnt_o, savedCnt);
                checkOutput("coincState", bus.state_o, PH_HOLD);
            end
        end
        checkOutput("coincReached", seen, 1);

        for (int i = 0; i < 35000 && mAbortTotal < 300; i++) applyStimulus(0, 0, 1, 0);
        checkOutput("abortTotal", mAbortTotal, 300);
        checkOutput("abortSat", bus.abort_cnt_o, 255);

        seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            applyStimulus(0, 0, 1, 0);
            seen = (mPhase == PH_LOCAL && mElapsed < 5);
        end
        checkOutput("preemptGrant", bus.rd_gnt_o, 1);
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            applyStimulus(1, 0, 1, 0);
            seen |= bus.preempt_o;
        end
        checkOutput("preemptSeen", seen, 1);
        applyStimulus(0, 0, 0, 1);
        for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 0);
        checkOutput("preemptWhich", bus.which_wr_o, 0);
        checkOutput("preemptFr", bus.frame_ready_o, 0);

        reqHold = 0; doneHold = 0; rdHold = 0;
        rReq = 0; rDone = 0; rRd = 0;
        for (int i = 0; i < 8000; i++) begin
            if (reqHold == 0) begin rReq = 1'($urandom_range(0, 1)); reqHold = $urandom_range(1, 45); end
            if (doneHold == 0) begin rDone = 1'($urandom_range(0, 1)); doneHold = $urandom_range(1, 45); end
            if (rdHold == 0) begin rRd = 1'($urandom_range(0, 1)); rdHold = $urandom_range(1, 60); end
            reqHold--; doneHold--; rdHold--;
            applyStimulus(rReq, rDone, rRd,
                          (mPhase == PH_LOCAL) ? ($urandom_range(0, 24) == 0) : ($urandom_range(0, 49) == 0));
        end

        // Reach a live grant, then yank reset mid-burst.
        for (int i = 0; i < 30; i++) applyStimulus(0, 0, 0, 0);
        for (int i = 0; i < 30; i++) applyStimulus(0, 1, 1, 0);
        seen = (mPhase == PH_LOCAL);
        for (int i = 0; i < 300 && !seen; i++) begin
            applyStimulus(0, 1, 1, 0);
            seen = (mPhase == PH_LOCAL);
        end
        checkOutput("midGrant", bus.rd_gnt_o, 1);
        @(negedge clk_48MHz);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midRstGnt", bus.rd_gnt_o, 0);
        checkOutput("midRstWhich", bus.which_wr_o, 0);
        checkOutput("midRstState", bus.state_o, 0);
        checkOutput("midRstFr", bus.frame_ready_o, 0);
        checkOutput("midRstAbortCnt", bus.abort_cnt_o, 0);
        @(negedge clk_48MHz);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
